// File: rtl/store_merge_pkg.sv
// rtl/store_merge_pkg.sv - size encodings, FSM states and alignment helper for the store path
package store_merge_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Reserved size is treated as a rejected access alongside true misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_HALF: return offset[0];
      SZ_WORD: return offset != 2'b00;
      SZ_RSVD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_merge_if.sv
// rtl/store_merge_if.sv - CPU request and memory bus signals of the store merge unit
interface store_merge_if;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic        misaligned;

  modport slave (
    input  start, size, addr, wdata, mem_rdata, mem_ready,
    output mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, misaligned
  );

  modport master (
    output start, size, addr, wdata, mem_rdata, mem_ready,
    input  mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, misaligned
  );
endinterface

// File: rtl/store_merge_lane_merge.sv
// rtl/store_merge_lane_merge.sv - combinational byte/halfword lane insert into a 32-bit word
module lane_merge
  import store_merge_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  output logic [31:0] merged
);

  logic [1:0] byte_lane;
  logic       half_lane;

  // Lane index counts from bit 0; big-endian mirrors the address offset.
  always_comb begin
    byte_lane = BIG_ENDIAN ? ~offset : offset;
    half_lane = BIG_ENDIAN ? ~offset[1] : offset[1];
    merged    = old_word;
    case (size)
      SZ_BYTE: merged[{byte_lane, 3'b000} +: 8]   = data[7:0];
      SZ_HALF: merged[{half_lane, 4'b0000} +: 16] = data[15:0];
      SZ_WORD: merged = data;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_merge.sv
// rtl/store_merge.sv - sub-word store via read-merge-write on a word-wide memory port
module store_merge
  import store_merge_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input logic           clk,
  input logic           reset,
  store_merge_if.slave  bus
);

  state_t      state;
  state_t      state_next;
  logic [31:0] addr_q;
  logic [31:0] word_q;
  logic [1:0]  size_q;
  logic [31:0] merged;

  lane_merge #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane_merge (
    .old_word (bus.mem_rdata),
    .data     (word_q),
    .offset   (addr_q[1:0]),
    .size     (size_q),
    .merged   (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_misaligned(bus.size, bus.addr[1:0])) state_next = ST_ERR;
          else if (bus.size == SZ_WORD)                state_next = ST_WRITE;
          else                                         state_next = ST_READ;
        end
      end
      ST_READ:  if (bus.mem_ready) state_next = ST_WRITE;
      ST_WRITE: if (bus.mem_ready) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      ST_ERR:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // word_q holds the store data until the read returns, then the merged word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= 32'h0;
      size_q <= SZ_BYTE;
      word_q <= 32'h0;
    end else if (state == ST_IDLE && bus.start) begin
      addr_q <= bus.addr;
      size_q <= bus.size;
      word_q <= bus.wdata;
    end else if (state == ST_READ && bus.mem_ready) begin
      word_q <= merged;
    end
  end

  always_comb begin
    bus.mem_rd     = (state == ST_READ);
    bus.mem_wr     = (state == ST_WRITE);
    bus.done       = (state == ST_DONE);
    bus.misaligned = (state == ST_ERR);
    bus.busy       = (state != ST_IDLE);
  end

  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = word_q;

endmodule

// File: tb/tb_store_merge.sv
// tb/tb_store_merge.sv - directed self-checking bench for store_merge in both endian modes
module tb_store_merge;

  typedef struct {
    bit          busy;
    bit          rd;
    bit          wr;
    bit          done;
    bit          mis;
    logic [31:0] addr;
    logic [31:0] wd_be;
    logic [31:0] wd_le;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  exp_t q[$];

  store_merge_if bus();
  store_merge_if bus_le();

  assign bus_le.start     = bus.start;
  assign bus_le.size      = bus.size;
  assign bus_le.addr      = bus.addr;
  assign bus_le.wdata     = bus.wdata;
  assign bus_le.mem_rdata = bus.mem_rdata;
  assign bus_le.mem_ready = bus.mem_ready;

  store_merge #(.BIG_ENDIAN(1'b1)) dut_be (.clk(clk), .reset(reset), .bus(bus.slave));
  store_merge #(.BIG_ENDIAN(1'b0)) dut_le (.clk(clk), .reset(reset), .bus(bus_le.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory viewed as four bytes in address order; the store overwrites its bytes.
  function automatic logic [31:0] model_merge(input bit be, input logic [1:0] sz,
                                               input logic [31:0] a, input logic [31:0] wd,
                                               input logic [31:0] old);
    logic [7:0]  b [4];
    logic [1:0]  o;
    logic [31:0] r;
    if (sz == 2'b10) return wd;
    o = a[1:0];
    for (int i = 0; i < 4; i++) b[i] = be ? old[31-8*i -: 8] : old[8*i +: 8];
    if (sz == 2'b00) begin
      b[o] = wd[7:0];
    end else begin
      b[o]        = be ? wd[15:8] : wd[7:0];
      b[o + 2'd1] = be ? wd[7:0]  : wd[15:8];
    end
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (be) r[31-8*i -: 8] = b[i];
      else    r[8*i +: 8]    = b[i];
    end
    return r;
  endfunction

  task automatic chk_dut(input string tag, input bit be, input exp_t e, input bit in_reset,
                         input logic busy, input logic rd, input logic wr, input logic done,
                         input logic mis, input logic [31:0] ma, input logic [31:0] wd);
    chk({tag, " busy"}, {31'h0, busy}, {31'h0, e.busy});
    chk({tag, " mem_rd"}, {31'h0, rd}, {31'h0, e.rd});
    chk({tag, " mem_wr"}, {31'h0, wr}, {31'h0, e.wr});
    chk({tag, " done"}, {31'h0, done}, {31'h0, e.done});
    chk({tag, " misaligned"}, {31'h0, mis}, {31'h0, e.mis});
    if (in_reset) begin
      chk({tag, " reset mem_addr"}, ma, 32'h0);
      chk({tag, " reset mem_wdata"}, wd, 32'h0);
    end
    if (e.rd || e.wr) chk({tag, " mem_addr"}, ma, e.addr);
    if (e.wr)         chk({tag, " mem_wdata"}, wd, be ? e.wd_be : e.wd_le);
  endtask

  always @(negedge clk) begin
    exp_t e;
    e = '{default: '0};
    if (!reset && q.size() > 0) e = q.pop_front();
    chk_dut("be", 1'b1, e, reset, bus.busy, bus.mem_rd, bus.mem_wr, bus.done,
            bus.misaligned, bus.mem_addr, bus.mem_wdata);
    chk_dut("le", 1'b0, e, reset, bus_le.busy, bus_le.mem_rd, bus_le.mem_wr, bus_le.done,
            bus_le.misaligned, bus_le.mem_addr, bus_le.mem_wdata);
  end

  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int stalls, input bit poke,
                          input logic [31:0] exp_be, input logic [31:0] exp_le);
    exp_t e;
    exp_t idle;
    bit   mis;
    bit   word;
    int   n;
    idle = '{default: '0};
    mis  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    word = (sz == 2'b10);
    if (!mis && !word) begin
      chk("model be", model_merge(1'b1, sz, a, wd, rdat), exp_be);
      chk("model le", model_merge(1'b0, sz, a, wd, rdat), exp_le);
    end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.size = sz; bus.addr = a; bus.wdata = wd;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBAD0_0000;
    q.push_back(idle);
    n = 0;
    e = '{default: '0};
    e.busy = 1'b1;
    e.addr = {a[31:2], 2'b00};
    if (mis) begin
      e.mis = 1'b1; q.push_back(e); n++;
    end else begin
      if (!word) begin
        e.rd = 1'b1;
        for (int i = 0; i <= stalls; i++) begin q.push_back(e); n++; end
        e.rd = 1'b0; e.wr = 1'b1;
        e.wd_be = model_merge(1'b1, sz, a, wd, rdat);
        e.wd_le = model_merge(1'b0, sz, a, wd, rdat);
        q.push_back(e); n++;
      end else begin
        e.wr = 1'b1; e.wd_be = wd; e.wd_le = wd;
        for (int i = 0; i <= stalls; i++) begin q.push_back(e); n++; end
      end
      e.wr = 1'b0; e.done = 1'b1;
      q.push_back(e); n++;
    end
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      bus.start = poke && (k == 2);
      if (bus.start) begin
        bus.size = 2'b00; bus.addr = 32'hFFFF_FFF2; bus.wdata = 32'h0000_0055;
      end
      bus.mem_ready = (k > stalls);
      bus.mem_rdata = (!word && k == stalls + 1) ? rdat : (32'hBAD0_0000 | k);
    end
  endtask

  task automatic reset_during_write();
    exp_t e;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.size = 2'b10; bus.addr = 32'h0000_0300; bus.wdata = 32'h0123_4567;
    bus.mem_ready = 1'b0;
    q.push_back('{default: '0});
    e = '{default: '0};
    e.busy = 1'b1; e.wr = 1'b1; e.addr = 32'h0000_0300;
    e.wd_be = 32'h0123_4567; e.wd_le = 32'h0123_4567;
    q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    q.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.size = 2'b00; bus.addr = 32'h0; bus.wdata = 32'h0;
    bus.mem_rdata = 32'h0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    do_store(2'b00, 32'h0000_0101, 32'h0000_00AB, 32'h1122_3344, 0, 1'b0, 32'h11AB_3344, 32'h1122_AB44);
    do_store(2'b01, 32'h0000_0102, 32'h0000_CAFE, 32'h1122_3344, 0, 1'b0, 32'h1122_CAFE, 32'hCAFE_3344);
    do_store(2'b10, 32'h0000_0200, 32'hDEAD_BEEF, 32'h1122_3344, 0, 1'b0, 32'h0, 32'h0);
    do_store(2'b01, 32'h0000_0103, 32'h0000_1111, 32'h1122_3344, 0, 1'b0, 32'h0, 32'h0);
    do_store(2'b10, 32'h0000_0202, 32'h2222_2222, 32'h1122_3344, 0, 1'b0, 32'h0, 32'h0);
    do_store(2'b11, 32'h0000_0100, 32'h3333_3333, 32'h1122_3344, 0, 1'b0, 32'h0, 32'h0);
    do_store(2'b00, 32'h0000_0100, 32'h1234_56C3, 32'hA5A5_A5A5, 3, 1'b1, 32'hC3A5_A5A5, 32'hA5A5_A5C3);
    do_store(2'b01, 32'h0000_0100, 32'hFFFF_0102, 32'h1122_3344, 1, 1'b0, 32'h0102_3344, 32'h1122_0102);
    do_store(2'b00, 32'h0000_0103, 32'h0000_0077, 32'h0000_0000, 0, 1'b0, 32'h0000_0077, 32'h7700_0000);
    do_store(2'b10, 32'hFFFF_FFFC, 32'h89AB_CDEF, 32'h0, 2, 1'b0, 32'h0, 32'h0);
    reset_during_write();
    do_store(2'b10, 32'h0000_0400, 32'hCAFE_BABE, 32'h0, 0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    if (q.size() != 0) chk("expectation queue drained", q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/store_merge.md
STORE_MERGE -- requirements
Module: store_merge

Interface
REQ-001 SHALL have parameter BIG_ENDIAN, default 1, meaning byte 0 of a word maps to bits 31:24 (0: byte 0 maps to bits 7:0).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a store; sampled only in IDLE.
REQ-005 SHALL have port size  input  2  00 byte (SB), 01 halfword (SH), 10 word (SW), 11 reserved.
REQ-006 SHALL have port addr  input  32  byte address of the store.
REQ-007 SHALL have port wdata  input  32  store data from rt; SB uses [7:0] and SH uses [15:0].
REQ-008 SHALL have port mem_addr  output  32  word-aligned memory address.
REQ-009 SHALL have port mem_rd  output  1  memory read request.
REQ-010 SHALL have port mem_wr  output  1  memory write request.
REQ-011 SHALL have port mem_wdata  output  32  merged word to write.
REQ-012 SHALL have port mem_rdata  input  32  memory read data, valid when mem_ready=1 during a read.
REQ-013 SHALL have port mem_ready  input  1  memory accepts or completes the current request this cycle.
REQ-014 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a store completes.
REQ-016 SHALL have port misaligned  output  1  one-cycle pulse when a store is rejected.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, DONE and ERR.
REQ-018 IDLE with start=1 SHALL register addr, size and wdata.
REQ-019 From IDLE with start=1, the next state SHALL be ERR if size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=00.
REQ-020 Otherwise from IDLE with start=1, the next state SHALL be WRITE for SW and READ for SB/SH.
REQ-021 READ SHALL assert mem_rd; on mem_ready=1 it SHALL register the merged word and go to WRITE, else stay in READ.
REQ-022 WRITE SHALL assert mem_wr with mem_wdata held stable; on mem_ready=1 it SHALL go to DONE.
REQ-023 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-024 ERR SHALL assert misaligned for exactly one cycle, then go to IDLE, with no mem_rd, mem_wr or done.
REQ-025 mem_addr SHALL equal {addr_q[31:2],2'b00} and stay constant from leaving IDLE until returning to IDLE.
REQ-026 mem_rd, mem_wr, done, misaligned and busy SHALL be Moore outputs decoded from state only.
REQ-027 mem_rd and mem_wr SHALL never be high in the same cycle.
REQ-028 Merge SHALL replace only the addressed lane (byte lane from addr_q[1:0]; halfword lane from addr_q[1]) and keep all other bits from mem_rdata.
REQ-029 With BIG_ENDIAN=1: byte offset 0 maps to bits 31:24, offset 3 to bits 7:0; halfword offset 0 maps to bits 31:16.
REQ-030 For SW, mem_wdata SHALL equal wdata_q unchanged.
REQ-031 With mem_ready tied high, latency from start to done SHALL be 2 cycles for SW and 3 cycles for SB/SH.
REQ-032 Each cycle with mem_ready=0 SHALL add one cycle of latency.
REQ-033 start while busy=1 SHALL be ignored, with no effect on registered operands.
REQ-034 mem_rdata SHALL be ignored outside READ.

Reset
REQ-035 Asserting reset SHALL immediately force IDLE and drive mem_rd, mem_wr, done, misaligned, busy to 0, and mem_addr, mem_wdata to 32'h0.
REQ-036 Reset asserted during READ or WRITE SHALL abandon the access with no done pulse.
REQ-037 After reset deassertion the first accepted start SHALL behave as in REQ-017 to REQ-032.

Structure
REQ-038 The shared CPU package SHALL hold the size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10) and the FSM state encoding.
REQ-039 Lane merging SHALL be a combinational sub-module lane_merge (inputs old word, data, offset, size, BIG_ENDIAN; output merged word).
REQ-040 lane_merge SHALL be reusable by the load-path extender for lane selection.

Verification
REQ-041 SB: addr=0x00000101, wdata=0x000000AB, mem_rdata=0x11223344, ready high, BIG_ENDIAN=1 -> mem_rd at 0x100 in cycle 1, mem_wr with 0x11AB3344 in cycle 2, done in cycle 3.
REQ-042 SH: addr=0x102, wdata=0x0000CAFE, mem_rdata=0x11223344 -> write 0x1122CAFE to 0x100; with BIG_ENDIAN=0 -> write 0xCAFE3344.
REQ-043 SW: addr=0x200, wdata=0xDEADBEEF -> mem_rd never high, mem_wr with 0xDEADBEEF at 0x200 in cycle 1, done in cycle 2.
REQ-044 SH addr=0x103, SW addr=0x202, and size=11 -> misaligned pulse in cycle 1, no mem_rd/mem_wr/done, busy low by cycle 2.
REQ-045 SB with mem_ready low 3 cycles in READ -> mem_rd and mem_addr held stable, done at cycle 6; start pulsed mid-operation -> ignored.
REQ-046 Reset asserted during WRITE -> mem_wr and busy drop in the same cycle, no done; a following SW completes normally.
